// File: rtl/ctrl_input_cond.sv
// Button conditioning: per-channel 2-flop sync + debounce, reset priority on outputs.
// Optional `CTRL_RUN_TOGGLE_EN turns btn_run into a start/stop toggle.
module ctrl_input_db #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_p,
  output logic stable
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             differ;

  assign differ = sync[1] ^ stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw_p};
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt    <= '0;
        stable <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module ctrl_input_cond #(
  parameter int DB_CYCLES  = 500000,
  parameter int CNT_W      = 20,
  parameter int ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_load,
  input  logic btn_run,
  input  logic btn_reset,
  output logic loadin,
  output logic runin,
  output logic resetin
);
  localparam int NUM_CH = 3;
  localparam logic [NUM_CH-1:0] POL = (ACTIVE_LOW != 0) ? '1 : '0;

  // channel order: [0] load, [1] run, [2] reset
  logic [NUM_CH-1:0] raw_p;
  logic [NUM_CH-1:0] stable;

  assign raw_p = {btn_reset, btn_run, btn_load} ^ POL;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ctrl_input_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_p  (raw_p[i]),
      .stable (stable[i])
    );
  end

  assign resetin = stable[2];
  assign loadin  = stable[0] & ~stable[2];

`ifdef CTRL_RUN_TOGGLE_EN
  // run_q folds in the rising edge so runin flips on the same cycle stable_run rises
  logic run_prev, run_lat, run_q;
  assign run_q = run_lat ^ (stable[1] & ~run_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_prev <= 1'b0;
      run_lat  <= 1'b0;
    end else begin
      run_prev <= stable[1];
      run_lat  <= stable[2] ? 1'b0 : run_q;
    end
  end

  assign runin = run_q & ~stable[2];
`else
  assign runin = stable[1] & ~stable[2];
`endif
endmodule

// File: tb/tb_ctrl_input_cond.sv
// Directed bench for ctrl_input_cond with DB_CYCLES=4; second instance covers ACTIVE_LOW=1.
module tb_ctrl_input_cond;
  logic clk = 1'b0;
  logic rst_n;
  logic btn_load, btn_run, btn_reset;
  logic loadin, runin, resetin;
  logic al_load, al_run, al_reset;
  logic al_loadin, al_runin, al_resetin;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ctrl_input_cond #(.DB_CYCLES(4), .CNT_W(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_load(btn_load), .btn_run(btn_run),
    .btn_reset(btn_reset), .loadin(loadin), .runin(runin), .resetin(resetin)
  );

  ctrl_input_cond #(.DB_CYCLES(4), .CNT_W(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_load(al_load), .btn_run(al_run),
    .btn_reset(al_reset), .loadin(al_loadin), .runin(al_runin), .resetin(al_resetin)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; btn_load = 1'b0; btn_run = 1'b0; btn_reset = 1'b0;
    al_load = 1'b1; al_run = 1'b1; al_reset = 1'b1;
    #12;
    chk("rst_outs", {loadin, runin, resetin}, 3'b000);
    chk("rst_al_outs", {al_loadin, al_runin, al_resetin}, 3'b000);
    tick(1);
    rst_n = 1'b1;
    tick(8);
    chk("idle_outs", {loadin, runin, resetin}, 3'b000);
    chk("al_idle_outs", {al_loadin, al_runin, al_resetin}, 3'b000);

    // load rise / fall latency
    btn_load = 1'b1;
    tick(5); chk("load_rise_early", loadin, 1'b0);
    tick(1); chk("load_rise", loadin, 1'b1);
    btn_load = 1'b0;
    tick(5); chk("load_fall_early", loadin, 1'b1);
    tick(1); chk("load_fall", loadin, 1'b0);

    // 3-cycle glitch on run never reaches the output
    btn_run = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(1); chk("glitch_hi", runin, 1'b0); end
    btn_run = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(1); chk("glitch_lo", runin, 1'b0); end
    chk("glitch_cnt", 32'(dut.g_ch[1].u_db.cnt), 32'd0);

    // reset priority over run
    btn_run = 1'b1; btn_reset = 1'b1;
    tick(6);
    chk("prio_resetin", resetin, 1'b1);
    chk("prio_runin", runin, 1'b0);
    btn_reset = 1'b0;
    tick(5); chk("prio_hold_resetin", resetin, 1'b1); chk("prio_hold_runin", runin, 1'b0);
    tick(1); chk("prio_rel_resetin", resetin, 1'b0);
`ifdef CTRL_RUN_TOGGLE_EN
    chk("prio_rel_runin", runin, 1'b0);
`else
    chk("prio_rel_runin", runin, 1'b1);
`endif
    btn_run = 1'b0;
    tick(6); chk("prio_run_off", runin, 1'b0);

    // simultaneous load + run pass through
    btn_load = 1'b1; btn_run = 1'b1;
    tick(6); chk("both_on", {loadin, runin}, 2'b11);
    btn_load = 1'b0; btn_run = 1'b0;
    tick(6); chk("both_off_load", loadin, 1'b0);
`ifdef CTRL_RUN_TOGGLE_EN
    chk("both_off_run", runin, 1'b1);
`else
    chk("both_off_run", runin, 1'b0);
`endif

    // run press sequence: second press stops in toggle mode, reset clears latch
    btn_run = 1'b1; tick(6);
`ifdef CTRL_RUN_TOGGLE_EN
    chk("seq_press2", runin, 1'b0);
`else
    chk("seq_press2", runin, 1'b1);
`endif
    btn_run = 1'b0; tick(6); chk("seq_rel2", runin, 1'b0);
    btn_run = 1'b1; tick(6); chk("seq_press3", runin, 1'b1);
    btn_run = 1'b0; tick(6);
`ifdef CTRL_RUN_TOGGLE_EN
    chk("seq_rel3", runin, 1'b1);
`else
    chk("seq_rel3", runin, 1'b0);
`endif
    btn_reset = 1'b1; tick(6);
    chk("seq_rst_resetin", resetin, 1'b1); chk("seq_rst_runin", runin, 1'b0);
    btn_reset = 1'b0; tick(6);
    chk("seq_rst_rel", {runin, resetin}, 2'b00);

    // active-low instance
    al_load = 1'b0;
    tick(5); chk("al_load_early", al_loadin, 1'b0);
    tick(1); chk("al_load", al_loadin, 1'b1);
    chk("al_others", {al_runin, al_resetin}, 2'b00);

    // async reset mid-debounce, then recovery with load held
    btn_load = 1'b1; tick(6); chk("pre_rst_load", loadin, 1'b1);
    btn_run = 1'b1; tick(3);
    rst_n = 1'b0; #1;
    chk("async_rst_outs", {loadin, runin, resetin}, 3'b000);
    chk("async_rst_al", al_loadin, 1'b0);
    chk("async_rst_cnt", 32'(dut.g_ch[1].u_db.cnt), 32'd0);
    tick(1);
    chk("rst_held_outs", {loadin, runin, resetin}, 3'b000);
    rst_n = 1'b1;
    tick(5); chk("rec_load_early", loadin, 1'b0);
    tick(1); chk("rec_load", loadin, 1'b1);
    chk("rec_run", runin, 1'b1);
    chk("rec_al_load", al_loadin, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
